// File: rtl/toggle_activity_monitor.sv
// Switching-activity sensor: counts toggles on mon_in over fixed windows and raises a
// sticky alarm after HOLD consecutive windows whose toggle total exceeds THRESH.
module toggle_activity_monitor #(
   parameter int WIDTH       = 1,
   parameter int WINDOW_LOG2 = 8,
   parameter int THRESH      = 64,
   parameter int HOLD        = 4,
   localparam int ACC_W      = WINDOW_LOG2 + $clog2(WIDTH + 1),
   localparam int HS_W       = $clog2(HOLD + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic [WIDTH-1:0] mon_in,
   input  logic             clr_alarm,
   output logic [ACC_W-1:0] win_count,
   output logic             win_valid,
   output logic [ACC_W-1:0] peak_count,
   output logic [HS_W-1:0]  hot_streak,
   output logic             alarm
);

   localparam logic [31:0]     THRESH_U = 32'(THRESH);
   localparam logic [HS_W-1:0] HOLD_S   = HS_W'(HOLD);

   logic [WIDTH-1:0]       prev_q, prev_d;
   logic [ACC_W-1:0]       acc_q, acc_d;
   logic [WINDOW_LOG2-1:0] cnt_q, cnt_d;
   logic                   primed_q, primed_d;
   logic [ACC_W-1:0]       win_count_q, win_count_d;
   logic                   win_valid_q, win_valid_d;
   logic [ACC_W-1:0]       peak_q, peak_d;
   logic [HS_W-1:0]        hot_streak_q, hot_streak_d;
   logic                   alarm_q, alarm_d;

   logic [ACC_W-1:0]       toggles_s;
   logic [ACC_W-1:0]       total_s;
   logic [ACC_W-1:0]       base_peak_s;
   logic [HS_W-1:0]        base_streak_s;
   logic                   base_alarm_s;
   logic                   hot_s;

   function automatic logic [ACC_W-1:0] popcount(input logic [WIDTH-1:0] v);
      logic [ACC_W-1:0] n;
      n = '0;
      for (int i = 0; i < WIDTH; i++) begin
         n = n + ACC_W'(v[i]);
      end
      return n;
   endfunction

   // Next-state computation for window accumulation, streak tracking and alarm
   always_comb begin
      prev_d      = prev_q;
      acc_d       = acc_q;
      cnt_d       = cnt_q;
      primed_d    = primed_q;
      win_count_d = win_count_q;
      win_valid_d = 1'b0;

      // A clear takes effect before any coinciding window-end evaluation
      base_peak_s   = clr_alarm ? '0 : peak_q;
      base_streak_s = clr_alarm ? '0 : hot_streak_q;
      base_alarm_s  = clr_alarm ? 1'b0 : alarm_q;
      peak_d        = base_peak_s;
      hot_streak_d  = base_streak_s;
      alarm_d       = base_alarm_s;

      toggles_s = primed_q ? popcount(mon_in ^ prev_q) : '0;
      total_s   = acc_q + toggles_s;
      hot_s     = 32'(total_s) > THRESH_U;

      if (en) begin
         prev_d   = mon_in;
         primed_d = 1'b1;
         cnt_d    = cnt_q + WINDOW_LOG2'(1);
         if (&cnt_q) begin
            acc_d       = '0;
            win_count_d = total_s;
            win_valid_d = 1'b1;
            peak_d      = (total_s > base_peak_s) ? total_s : base_peak_s;
            if (hot_s) begin
               hot_streak_d = (base_streak_s >= HOLD_S) ? HOLD_S : base_streak_s + HS_W'(1);
               alarm_d      = base_alarm_s | (hot_streak_d == HOLD_S);
            end else begin
               hot_streak_d = '0;
            end
         end else begin
            acc_d = total_s;
         end
      end else begin
         primed_d = 1'b0;
      end
   end

   // State registers with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         prev_q       <= '0;
         acc_q        <= '0;
         cnt_q        <= '0;
         primed_q     <= 1'b0;
         win_count_q  <= '0;
         win_valid_q  <= 1'b0;
         peak_q       <= '0;
         hot_streak_q <= '0;
         alarm_q      <= 1'b0;
      end else begin
         prev_q       <= prev_d;
         acc_q        <= acc_d;
         cnt_q        <= cnt_d;
         primed_q     <= primed_d;
         win_count_q  <= win_count_d;
         win_valid_q  <= win_valid_d;
         peak_q       <= peak_d;
         hot_streak_q <= hot_streak_d;
         alarm_q      <= alarm_d;
      end
   end

   assign win_count  = win_count_q;
   assign win_valid  = win_valid_q;
   assign peak_count = peak_q;
   assign hot_streak = hot_streak_q;
   assign alarm      = alarm_q;

endmodule

// File: tb/tb_toggle_activity_monitor.sv
// Directed bench for toggle_activity_monitor with a 16-cycle window, THRESH=8, HOLD=2.
module tb_toggle_activity_monitor;

   localparam int WIDTH       = 1;
   localparam int WINDOW_LOG2 = 4;
   localparam int THRESH      = 8;
   localparam int HOLD        = 2;
   localparam int ACC_W       = WINDOW_LOG2 + $clog2(WIDTH + 1);
   localparam int HS_W        = $clog2(HOLD + 1);

   logic             clk = 1'b0;
   logic             rst;
   logic             en;
   logic [WIDTH-1:0] mon_in;
   logic             clr_alarm;
   logic [ACC_W-1:0] win_count;
   logic             win_valid;
   logic [ACC_W-1:0] peak_count;
   logic [HS_W-1:0]  hot_streak;
   logic             alarm;

   int n_cmp  = 0;
   int n_fail = 0;

   toggle_activity_monitor #(
      .WIDTH(WIDTH), .WINDOW_LOG2(WINDOW_LOG2), .THRESH(THRESH), .HOLD(HOLD)
   ) dut (
      .clk(clk), .rst(rst), .en(en), .mon_in(mon_in), .clr_alarm(clr_alarm),
      .win_count(win_count), .win_valid(win_valid), .peak_count(peak_count),
      .hot_streak(hot_streak), .alarm(alarm)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic chk_outs(input string tag, input int wc, input int wv, input int pk,
                           input int hs, input int al);
      chk({tag, ".win_count"},  32'(win_count),  32'(wc));
      chk({tag, ".win_valid"},  32'(win_valid),  32'(wv));
      chk({tag, ".peak_count"}, 32'(peak_count), 32'(pk));
      chk({tag, ".hot_streak"}, 32'(hot_streak), 32'(hs));
      chk({tag, ".alarm"},      32'(alarm),      32'(al));
   endtask

   task automatic do_reset();
      rst = 1'b1; en = 1'b0; clr_alarm = 1'b0; mon_in = '0;
      tick();
      tick();
      rst = 1'b0;
   endtask

   // One full enabled window; the first n_tog cycles flip mon_in before the edge
   task automatic run_window(input int n_tog, input bit clr_last);
      en = 1'b1;
      for (int i = 0; i < 16; i++) begin
         if (i < n_tog) mon_in = ~mon_in;
         clr_alarm = clr_last && (i == 15);
         tick();
      end
      clr_alarm = 1'b0;
   endtask

   initial begin
      do_reset();
      chk_outs("reset", 0, 0, 0, 0, 0);

      // 1: quiet input, pulses every 16 cycles
      en = 1'b1;
      for (int i = 0; i < 64; i++) begin
         tick();
         chk("t1.win_valid", 32'(win_valid), 32'((i % 16) == 15));
         if ((i % 16) == 15) chk("t1.win_count", 32'(win_count), 32'd0);
      end
      chk_outs("t1.end", 0, 1, 0, 0, 0);

      // 2: alternating input from reset, priming window loses one toggle
      do_reset();
      en = 1'b1;
      for (int i = 0; i < 32; i++) begin
         mon_in = ~mon_in;
         tick();
         if (i == 15) chk_outs("t2.w1", 15, 1, 15, 1, 0);
         if (i == 31) chk_outs("t2.w2", 16, 1, 16, 2, 1);
      end

      // 3: threshold boundary, 8 is not hot, 9 is
      do_reset();
      run_window(9, 1'b0);
      chk_outs("t3.eight", 8, 1, 8, 0, 0);
      run_window(9, 1'b0);
      chk_outs("t3.nine", 9, 1, 9, 1, 0);

      // 4: a cold window breaks the streak
      do_reset();
      run_window(0, 1'b0);
      chk_outs("t4.prime", 0, 1, 0, 0, 0);
      run_window(16, 1'b0);
      chk_outs("t4.hot1", 16, 1, 16, 1, 0);
      run_window(0, 1'b0);
      chk_outs("t4.cold", 0, 1, 16, 0, 0);
      run_window(16, 1'b0);
      chk_outs("t4.hot2", 16, 1, 16, 1, 0);
      run_window(16, 1'b0);
      chk_outs("t4.hot3", 16, 1, 16, 2, 1);

      // 6a: clear on a hot window end restarts streak from zero
      run_window(16, 1'b1);
      chk_outs("t6.clr_end", 16, 1, 16, 1, 0);

      // clear mid-window zeroes peak and streak, accumulation unaffected
      en = 1'b1;
      for (int i = 0; i < 16; i++) begin
         mon_in = ~mon_in;
         clr_alarm = (i == 2);
         tick();
         if (i == 2) begin
            chk("t6.mid.peak", 32'(peak_count), 32'd0);
            chk("t6.mid.streak", 32'(hot_streak), 32'd0);
         end
      end
      clr_alarm = 1'b0;
      chk_outs("t6.mid.end", 16, 1, 16, 1, 0);

      // 5: en gap at window cycle 6 pauses the counter and re-primes
      do_reset();
      for (int i = 0; i < 21; i++) begin
         en = !(i >= 6 && i < 11);
         mon_in = ~mon_in;
         tick();
         chk("t5.win_valid", 32'(win_valid), 32'(i == 20));
      end
      chk_outs("t5.end", 14, 1, 14, 1, 0);

      // 6b: reset at window cycle 10 discards the partial window
      en = 1'b1;
      for (int i = 0; i < 10; i++) begin
         mon_in = ~mon_in;
         tick();
      end
      rst = 1'b1;
      mon_in = ~mon_in;
      tick();
      chk_outs("t6.rst", 0, 0, 0, 0, 0);
      rst = 1'b0;
      for (int i = 0; i < 16; i++) begin
         mon_in = ~mon_in;
         tick();
         if (i < 15) chk("t6.post.win_valid", 32'(win_valid), 32'd0);
      end
      chk_outs("t6.post", 15, 1, 15, 1, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/toggle_activity_monitor.md
Name: toggle_activity_monitor

Overview:
- Defensive on-chip sensor that consumes the 1-bit payload node of a power-drain trojan stage, or any monitored bus, and measures switching activity over fixed windows.
- Raises a sticky alarm when activity stays above a threshold for a programmable number of consecutive windows.
- Sits directly downstream of the trigger/payload stage. Its outputs feed the detection/logging path.

Parameters:
- WIDTH, 1: width of the monitored bus.
- WINDOW_LOG2, 8: window length is 2^WINDOW_LOG2 enabled cycles.
- THRESH, 64: a window is "hot" when its toggle total is strictly greater than THRESH.
- HOLD, 4: number of consecutive hot windows required to set the alarm (HOLD >= 1).
- ACC_W (localparam): WINDOW_LOG2 + clog2(WIDTH+1). The full-window maximum always fits, so no saturation is needed.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- en  in  1  monitoring enable.
- mon_in  in  WIDTH  monitored node(s).
- clr_alarm  in  1  clears alarm, hot streak and peak.
- win_count  out  ACC_W  toggle total of the last completed window.
- win_valid  out  1  one-cycle pulse when win_count updates.
- peak_count  out  ACC_W  maximum win_count since reset or clr_alarm.
- hot_streak  out  clog2(HOLD+1)  consecutive hot windows, saturating at HOLD.
- alarm  out  1  sticky anomaly flag.

Behaviour:
- Reset (rst=1 at posedge): all outputs are 0.
  - Internal prev, acc and cycle counter are 0.
  - primed is 0.
- Priming:
  - The first enabled cycle after reset or after en was low loads prev <= mon_in and sets primed.
  - That cycle counts as a window cycle with 0 toggles.
- Per enabled primed cycle: t = popcount(mon_in ^ prev); prev <= mon_in.
- en=0:
  - The cycle counter and acc hold.
  - primed clears; prev is not updated.
  - No toggles are counted; win_valid stays 0.
- Cycle counter:
  - Counts 0..2^WINDOW_LOG2-1 on enabled cycles.
  - At the last count it wraps to 0, and that cycle is the window-end cycle.
- Window end (registered, visible the next cycle):
  - win_count <= acc + t.
  - win_valid <= 1 for exactly one cycle.
  - acc <= 0.
  - peak_count <= max(peak_count, acc + t).
- Hot evaluation at window end, with total = acc + t:
  - If total > THRESH: hot_streak <= min(hot_streak+1, HOLD).
  - Otherwise: hot_streak <= 0.
  - alarm <= 1 when the new hot_streak == HOLD. alarm, win_count and hot_streak update in the same cycle as win_valid.
- alarm is sticky: it is cleared only by rst or clr_alarm.
- clr_alarm on a non-window-end cycle: alarm <= 0, hot_streak <= 0, peak_count <= 0. Window accumulation is unaffected.
- clr_alarm coinciding with window end:
  - The clear applies first.
  - The completing window is evaluated from hot_streak=0 and peak=0: hot_streak <= hot?1:0, peak_count <= total.
  - alarm <= 1 only if HOLD==1 and the window is hot.
- Reset mid-window discards the partial window. No win_valid is generated.
- Latency: window end to outputs is 1 cycle. Ignoring en gaps, a monitored toggle affects win_count at most 2^WINDOW_LOG2 + 1 cycles later.
- No combinational path from inputs to outputs.

Test Plan:
Common configuration: WIDTH=1, WINDOW_LOG2=4 (16-cycle window), THRESH=8, HOLD=2.
1. en=1 with constant mon_in=0 for 64 cycles:
   - win_valid pulses every 16 cycles, first at cycle 17 after en.
   - win_count=0, hot_streak=0, alarm=0.
2. mon_in alternating 1/0 every cycle (rotating 0xAAAA… payload pattern):
   - First window win_count=15 (priming cycle), second =16.
   - hot_streak goes 1 then 2; alarm rises on the second win_valid; peak_count=16.
3. Exactly 8 toggles in a window gives win_count=8 and hot_streak=0. Exactly 9 toggles gives win_count=9 and hot_streak=1, with no alarm.
4. Window sequence hot(16), cold(0), hot(16):
   - hot_streak goes 1, 0, 1 and alarm stays 0.
   - A further hot window sets alarm.
5. en dropped for 5 cycles at window cycle 6 with alternating input, then re-enabled:
   - The counter pauses and the re-enable cycle re-primes with no toggle.
   - Window completes 5 cycles late with win_count=14.
6. Boundary events:
   - After alarm, clr_alarm pulsed exactly on a hot window-end cycle: alarm=0, hot_streak=1, peak_count=16.
   - rst asserted at window cycle 10: all outputs are 0 and there is no win_valid.
   - After rst: next window counts from the priming cycle.
